// File: rtl/fu_occupancy_tracker.sv
// Functional-unit occupancy tracker.
// Tracks busy periods for four SIMD ALUs, four SIMF ALUs and the SALU with
// down-counters, and outstanding LSU operations with a credit counter. Ready
// outputs come only from registered state. Any malformed or refused issue,
// and any LSU retire that would overflow the credits, sets a sticky error.
module fu_occupancy_tracker #(
    parameter int SIMD_LAT    = 4,
    parameter int SIMF_LAT    = 8,
    parameter int SALU_LAT    = 1,
    parameter int LSU_CREDITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c_issued_valid,
    input  logic [3:0] c_simd_select,
    input  logic [3:0] c_simf_select,
    input  logic       c_lsu_select,
    input  logic       c_salu_select,
    input  logic       lsu_done,
    output logic [3:0] f_simd_ready,
    output logic [3:0] f_simf_ready,
    output logic       f_lsu_ready,
    output logic       f_salu_ready,
    output logic       all_idle,
    output logic       err_protocol
);

    localparam logic [3:0] SIMD_LOAD  = 4'(SIMD_LAT);
    localparam logic [3:0] SIMF_LOAD  = 4'(SIMF_LAT);
    localparam logic [3:0] SALU_LOAD  = 4'(SALU_LAT);
    localparam logic [2:0] CREDIT_MAX = 3'(LSU_CREDITS);

    logic [3:0] simd_cnt [4];
    logic [3:0] simf_cnt [4];
    logic [3:0] salu_cnt;
    logic [2:0] credits;

    logic [9:0] sel_vec;
    logic [9:0] ready_vec;
    logic       sel_onehot;
    logic       issue_ok;
    logic       lsu_issue;
    logic       lsu_overflow;
    logic       bad_issue;
    logic       counters_zero;

    // A counter reloads on an accepted issue, otherwise counts down to zero.
    function automatic logic [3:0] next_count(input logic [3:0] cnt,
                                              input logic       load,
                                              input logic [3:0] lat);
        if (load)
            return lat;
        else if (cnt != 4'd0)
            return cnt - 4'd1;
        else
            return cnt;
    endfunction

    // Ready flags derive from the registered counters and credits only.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        f_simd_ready  = '0;
        f_simf_ready  = '0;
        counters_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f_simd_ready[i] = (simd_cnt[i] == 4'd0);
            f_simf_ready[i] = (simf_cnt[i] == 4'd0);
            if (simd_cnt[i] != 4'd0 || simf_cnt[i] != 4'd0)
                counters_zero = 1'b0;
        end
        f_salu_ready = (salu_cnt == 4'd0);
        f_lsu_ready  = (credits != 3'd0);
        if (salu_cnt != 4'd0)
            counters_zero = 1'b0;
    end

    // Issue qualification: exactly one select, target ready, valid asserted.
    always_comb begin
        sel_vec      = {c_salu_select, c_lsu_select, c_simf_select, c_simd_select};
        ready_vec    = {f_salu_ready, f_lsu_ready, f_simf_ready, f_simd_ready};
        sel_onehot   = (sel_vec != 10'd0) && ((sel_vec & (sel_vec - 10'd1)) == 10'd0);
        issue_ok     = c_issued_valid && sel_onehot && ((sel_vec & ready_vec) != 10'd0);
        bad_issue    = c_issued_valid && !issue_ok;
        lsu_issue    = issue_ok && c_lsu_select;
        lsu_overflow = lsu_done && !lsu_issue && (credits == CREDIT_MAX);
    end

    // Occupancy counters for the SIMD, SIMF and SALU units.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                simd_cnt[i] <= 4'd0;
                simf_cnt[i] <= 4'd0;
            end
            salu_cnt <= 4'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            for (int i = 0; i < 4; i++) begin
                simd_cnt[i] <= next_count(simd_cnt[i], issue_ok && c_simd_select[i], SIMD_LOAD);
                simf_cnt[i] <= next_count(simf_cnt[i], issue_ok && c_simf_select[i], SIMF_LOAD);
            end
            salu_cnt <= next_count(salu_cnt, issue_ok && c_salu_select, SALU_LOAD);
        end
    end

    // LSU credits: issue consumes, retire returns, both together cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CREDIT_MAX;
        end else begin
            case ({lsu_issue, lsu_done})
                2'b10:   credits <= credits - 3'd1;
                2'b01:   if (credits != CREDIT_MAX) credits <= credits + 3'd1;
                default: credits <= credits;
            endcase
        end
    end

    // Registered idle indication and sticky protocol-error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            all_idle     <= 1'b1;
            err_protocol <= 1'b0;
        end else begin
            all_idle <= counters_zero && (credits == CREDIT_MAX);
            if (bad_issue || lsu_overflow)
                err_protocol <= 1'b1;
        end
    end

endmodule

// File: doc/fu_occupancy_tracker.md
FU_OCCUPANCY_TRACKER -- requirements
Module: fu_occupancy_tracker

Interface
REQ-001: The block SHALL take these parameters (name, default, meaning):
- SIMD_LAT, 4: SIMD ALU occupancy in cycles; legal range 1..15.
- SIMF_LAT, 8: SIMF ALU occupancy in cycles; legal range 1..15.
- SALU_LAT, 1: SALU occupancy in cycles; legal range 1..15.
- LSU_CREDITS, 2: maximum number of outstanding LSU operations; legal range 1..7.
REQ-002: The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: reset; asynchronous, active-low.
- c_issued_valid, in, 1: an issue occurs this cycle.
- c_simd_select, in, 4: one-hot selects for SIMD ALUs 0..3.
- c_simf_select, in, 4: one-hot selects for SIMF ALUs 0..3.
- c_lsu_select, in, 1: LSU select.
- c_salu_select, in, 1: SALU select.
- lsu_done, in, 1: one-cycle pulse; one LSU operation has retired.
- f_simd_ready, out, 4: per-ALU ready for SIMD ALUs 0..3.
- f_simf_ready, out, 4: per-ALU ready for SIMF ALUs 0..3.
- f_lsu_ready, out, 1: LSU ready.
- f_salu_ready, out, 1: SALU ready.
- all_idle, out, 1: every unit is idle.
- err_protocol, out, 1: sticky protocol-error flag.

Function
REQ-003: The block SHALL keep one 4-bit down-counter per SIMD ALU, per SIMF ALU and for the SALU, 9 counters in total.
REQ-004: Each counter's ready output SHALL equal (counter == 0), taken combinationally from the registered counter.
REQ-005: An issue is accepted on a rising edge when all of the following hold: c_issued_valid=1, exactly one select bit is 1 across all ten selects, and the target unit is ready.
REQ-006: On an accepted issue to a counter unit, that unit's counter SHALL load its class LAT at the next edge.
REQ-007: Timing of an accepted issue to a counter unit:
- Issue in cycle t -> ready=0 in cycles t+1..t+LAT.
- Ready=1 again from cycle t+LAT+1.
REQ-008: A nonzero counter SHALL decrement by 1 each cycle, SHALL stop at 0 and SHALL never wrap.
REQ-009: The block SHALL keep an LSU credit counter, 3 bits, reset value LSU_CREDITS, with f_lsu_ready = (credits != 0).
REQ-010: Credit counter update rules:
- Accepted LSU issue only: credits decrement by 1.
- lsu_done only: credits increment by 1.
- Accepted LSU issue and lsu_done in the same cycle: credits unchanged.
REQ-011: When lsu_done=1 with credits==LSU_CREDITS and no accepted LSU issue in the same cycle, credits SHALL stay unchanged (saturate) and err_protocol SHALL set.
REQ-012: When c_issued_valid=1 and the selected unit is not ready, the issue SHALL be ignored, no counter changes, and err_protocol SHALL set.
REQ-013: When c_issued_valid=1 and the select bits are zero or more than one bit is 1, the issue SHALL be ignored, no counter changes, and err_protocol SHALL set.
REQ-014: Select bits SHALL be don't-care while c_issued_valid=0.
REQ-015: err_protocol SHALL be sticky: once set, it SHALL stay at 1 until reset.
REQ-016: all_idle SHALL be a registered output equal to 1 exactly when, in the previous cycle, all 9 counters were 0 and credits were LSU_CREDITS.
REQ-017: A busy unit SHALL not affect any other unit; different units may be busy at the same time and count independently.
REQ-018: There SHALL be no combinational path from the select inputs to any ready output; every ready output SHALL come from registered state only.

Reset
REQ-019: While rst=0, the block SHALL hold these values, asynchronously and independent of clk:
- All counters = 0.
- Credits = LSU_CREDITS.
- All f_*_ready = 1.
- all_idle = 1.
- err_protocol = 0.
REQ-020: Reset asserted mid-occupancy SHALL abort all busy periods; the first clk edge after rst returns to 1 SHALL find every unit ready.

Verification
REQ-021: The verification bench SHALL cover these directed scenarios (stimulus -> required response, default parameters):
- Issue to SIMD2 at cycle 10 -> f_simd_ready[2]=0 in cycles 11..14 and =1 at cycle 15; all other SIMD ready bits stay 1; all_idle=0 in cycles 12..15 and =1 at cycle 16.
- Issue to SALU at cycle 5 -> f_salu_ready=0 in cycle 6 only; issue to SALU again at cycle 7 is accepted with err_protocol=0.
- Two LSU issues at cycles 1 and 2 -> f_lsu_ready=0 from cycle 3; lsu_done at cycle 6 -> f_lsu_ready=1 at cycle 7; a simultaneous LSU issue and lsu_done at cycle 7 -> credits stay at 1.
- Issue to SIMF0 while it is busy, or c_issued_valid=1 with selects 0x3 on SIMD -> no counter changes and err_protocol=1 from the next cycle until reset.
- lsu_done with credits=2 -> credits stay at 2 and err_protocol=1.
- rst pulled low at cycle 3 of an SIMF occupancy (mid-cycle, asynchronous) -> all ready outputs =1 immediately and err_protocol=0.
